onehot_dec5_32: RTL and testbench

- Registered 5-to-32 one-hot decoder with enable, built hierarchically from one 2:4 and four 3:8 enable-gated decoders.
- Used as the register-file write-select / address decoder in the ARM processor datapath.
- Provides both a combinational decode and a clocked, reset-cleared copy.

---
 rtl/dec_pkg.sv | 9 +
 rtl/decoder2_4.sv | 15 +
 rtl/decoder3_8.sv | 15 +
 rtl/onehot_dec5_32.sv | 52 +++++
 tb/tb_onehot_dec5_32.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/dec_pkg.sv
// Shared widths and types for the 5-to-32 one-hot select decoder.
package dec_pkg;

    localparam int DEC_SEL_W = 5;
    localparam int DEC_OUT_W = 32;

    typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

endpackage

// File: rtl/decoder2_4.sv
// Enable-gated 2:4 decoder; produces the group enables for the 3:8 leaves.
module decoder2_4 (
    input  logic       en,
    input  logic [1:0] in,
    output logic [3:0] out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < 4; i++) begin
            out[i] = en & (in == 2'(i));
        end
    end

endmodule

// File: rtl/decoder3_8.sv
// Enable-gated 3:8 decoder; one instance per group of eight select lines.
module decoder3_8 (
    input  logic       en,
    input  logic [2:0] in,
    output logic [7:0] out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < 8; i++) begin
            out[i] = en & (in == 3'(i));
        end
    end

endmodule

// File: rtl/onehot_dec5_32.sv
// Register-file write-select decoder: 2:4 group stage feeding four 3:8 leaves,
// with an optional reset-cleared output register.
module onehot_dec5_32
    import dec_pkg::*;
#(
    parameter bit OUT_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DEC_SEL_W-1:0] in,
    output logic [DEC_OUT_W-1:0] out_comb,
    output logic [DEC_OUT_W-1:0] out
);

    logic [3:0] grp_en;

    decoder2_4 u_grp (
        .en  (en),
        .in  (in[4:3]),
        .out (grp_en)
    );

    for (genvar k = 0; k < 4; k++) begin : g_leaf
        decoder3_8 u_leaf (
            .en  (grp_en[k]),
            .in  (in[2:0]),
            .out (out_comb[8*k +: 8])
        );
    end

    if (OUT_REG) begin : g_reg
        dec_onehot_t out_d;
        dec_onehot_t out_q;

        always_comb out_d = out_comb;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q <= '0;
            end else begin
                out_q <= out_d;
            end
        end

        assign out = out_q;
    end else begin : g_comb
        // Unregistered build: clock and reset intentionally do not reach out.
        assign out = out_comb;
    end

endmodule

// File: tb/tb_onehot_dec5_32.sv
// Self-checking bench for onehot_dec5_32: registered and unregistered builds.
module tb_onehot_dec5_32;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [4:0]  sel;
    logic [31:0] comb_r, out_r, comb_c, out_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic [4:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    onehot_dec5_32 #(.OUT_REG(1'b1)) dut_r (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in       (sel),
        .out_comb (comb_r),
        .out      (out_r)
    );

    onehot_dec5_32 #(.OUT_REG(1'b0)) dut_c (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in       (sel),
        .out_comb (comb_c),
        .out      (out_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_dec(logic e, logic [4:0] s);
        logic [31:0] r;
        r = '0;
        if (e) r[s] = 1'b1;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_q;
        int          grp_seq[6];

        rst_n = 1'b0;
        en    = 1'b0;
        sel   = '0;

        tbl.push_back('{1'b1, 5'd5,  32'h0000_0020});
        tbl.push_back('{1'b1, 5'd31, 32'h8000_0000});
        tbl.push_back('{1'b1, 5'd0,  32'h0000_0001});
        tbl.push_back('{1'b1, 5'd16, 32'h0001_0000});
        tbl.push_back('{1'b0, 5'd31, 32'h0000_0000});
        tbl.push_back('{1'b0, 5'd0,  32'h0000_0000});
        for (int v = 0; v < 64; v++) begin
            vec_t e;
            e.en  = v[5];
            e.sel = v[4:0];
            e.exp = ref_dec(v[5], v[4:0]);
            tbl.push_back(e);
        end

        #2;
        chk("reset_out", out_r, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational table sweep
        foreach (tbl[i]) begin
            @(negedge clk);
            en  = tbl[i].en;
            sel = tbl[i].sel;
            #1;
            chk("comb_r", comb_r, tbl[i].exp);
            chk("comb_c", comb_c, tbl[i].exp);
            chk("out_c", out_c, tbl[i].exp);
        end

        // Registered latency after reset
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("reset_async_clear", out_r, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        sel   = 5'd9;
        #1;
        chk("latency_before", out_r, 32'h0);
        after_edge();
        chk("latency_after", out_r, 32'h0000_0200);

        // Async reset between edges
        @(negedge clk);
        sel = 5'd16;
        after_edge();
        chk("pre_reset", out_r, 32'h0001_0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", out_r, 32'h0);
        chk("comb_in_reset", comb_r, 32'h0001_0000);
        chk("out_c_in_reset", out_c, 32'h0001_0000);
        after_edge();
        chk("reset_hold1", out_r, 32'h0);
        after_edge();
        chk("reset_hold2", out_r, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("out_c_after_reset", out_c, 32'h0001_0000);

        // Enable drop
        @(negedge clk);
        en  = 1'b1;
        sel = 5'd3;
        after_edge();
        chk("en_pre", out_r, 32'h0000_0008);
        en = 1'b0;
        #1;
        chk("en_drop_comb", comb_r, 32'h0);
        chk("en_drop_hold", out_r, 32'h0000_0008);
        after_edge();
        chk("en_drop_out", out_r, 32'h0);

        // Group boundaries on consecutive cycles
        grp_seq = '{7, 8, 15, 16, 23, 24};
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sel = 5'(grp_seq[i]);
            after_edge();
            chk("grp_bit", out_r, 32'h1 << grp_seq[i]);
            chk("grp_popcount", 32'($countones(out_r)), 32'd1);
        end

        // Randomized against the reference model
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            en  = ($urandom_range(0, 3) != 0);
            sel = 5'($urandom_range(0, 31));
            exp_q = ref_dec(en, sel);
            #1;
            chk("rnd_comb", comb_r, exp_q);
            chk("rnd_out_c", out_c, exp_q);
            after_edge();
            chk("rnd_out_r", out_r, exp_q);
            chk("rnd_popcount", 32'($countones(out_r)), {31'd0, en});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
